// File: rtl/umem_pkg.sv
// Shared definitions for the unified-memory arbiter: who owns the memory
// transaction in flight, default timing parameters and a counter-width helper.
package umem_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int DEF_LAT        = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Bits needed to hold any value in 0..maxVal (never less than one bit).
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/umem_prio_sel.sv
// Winner selection between fetch and data requests. Data normally wins, but
// after STARVE_MAX contested data wins the fetch side is forced through once.
module umem_prio_sel
  import umem_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int SW         = cntWidth(STARVE_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic          d_req,
  input  logic          free,
  output logic          sel_i,
  output logic          sel_d,
  output logic [SW-1:0] scnt
);

  logic [SW-1:0] r_scnt;
  logic          w_starved;
  logic          w_selI;
  logic          w_selD;

  assign w_starved = (r_scnt == SW'(STARVE_MAX));

  // Pick at most one winner, and only when the memory can take a new request.
  always_comb begin
    w_selI = 1'b0;
    w_selD = 1'b0;
    if (free) begin
      if (i_req && d_req) begin
        if (w_starved) begin
          w_selI = 1'b1;
        end else begin
          w_selD = 1'b1;
        end
      end else if (i_req) begin
        w_selI = 1'b1;
      end else if (d_req) begin
        w_selD = 1'b1;
      end
    end
  end

  // Count data wins that left a fetch waiting; a fetch win wipes the slate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scnt <= '0;
    end else if (w_selI) begin
      r_scnt <= '0;
    end else if (w_selD && i_req && !w_starved) begin
      r_scnt <= r_scnt + 1'b1;
    end
  end

  assign sel_i = w_selI;
  assign sel_d = w_selD;
  assign scnt  = r_scnt;

endmodule

// File: rtl/umem_arbiter.sv
// Shares one single-port memory between the fetch port and the data port.
// One transaction is outstanding at a time; its response arrives LAT cycles
// after acceptance, and a new request may be accepted in that same cycle.
module umem_arbiter
  import umem_pkg::*;
#(
  parameter int LAT        = DEF_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW/8-1:0] d_byteen,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_byteen,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int CW = cntWidth(LAT);
  localparam int SW = cntWidth(STARVE_MAX);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  owner_e        r_owner;
  owner_e        w_ownerNext;
  logic          r_we;
  logic          w_weNext;

  logic          w_free;
  logic          w_resp;
  logic          w_grant;
  logic          w_selI;
  logic          w_selD;
  logic [SW-1:0] w_scnt;

  // Gating with reset keeps every output quiet while reset is held.
  assign w_free  = reset && ((r_cnt == '0) || (r_cnt == CW'(1)));
  assign w_resp  = reset && (r_cnt == CW'(1));
  assign w_grant = w_selI || w_selD;

  umem_prio_sel #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_prioSel (
    .clk   (clk),
    .reset (reset),
    .i_req (i_req),
    .d_req (d_req),
    .free  (w_free),
    .sel_i (w_selI),
    .sel_d (w_selD),
    .scnt  (w_scnt)
  );

  assign i_gnt = w_selI;
  assign d_gnt = w_selD;

  // Steer the winner's request onto the memory; reads never carry enables.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_byteen = '0;
    mem_wdata  = '0;
    if (w_selI) begin
      mem_req  = 1'b1;
      mem_addr = i_addr;
    end else if (w_selD) begin
      mem_req  = 1'b1;
      mem_we   = d_we;
      mem_addr = d_addr;
      if (d_we) begin
        mem_byteen = d_byteen;
        mem_wdata  = d_wdata;
      end
    end
  end

  // Route the memory response to whichever port owns the finishing access.
  always_comb begin
    i_rvalid = 1'b0;
    i_rdata  = '0;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    if (w_resp) begin
      if (r_owner == OWN_I) begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end else if (r_owner == OWN_D) begin
        d_rvalid = 1'b1;
        if (!r_we) begin
          d_rdata = mem_rdata;
        end
      end
    end
  end

  // A grant restarts the latency countdown; otherwise count down to idle.
  always_comb begin
    w_cntNext   = r_cnt;
    w_ownerNext = r_owner;
    w_weNext    = r_we;
    if (w_grant) begin
      w_cntNext   = CW'(LAT);
      w_ownerNext = w_selI ? OWN_I : OWN_D;
      w_weNext    = w_selD && d_we;
    end else if (r_cnt != '0) begin
      w_cntNext = r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        w_ownerNext = OWN_NONE;
        w_weNext    = 1'b0;
      end
    end
  end

  // Transaction bookkeeping; reset drops any access still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_owner <= OWN_NONE;
      r_we    <= 1'b0;
    end else begin
      r_cnt   <= w_cntNext;
      r_owner <= w_ownerNext;
      r_we    <= w_weNext;
    end
  end

  aGntExclusive: assert property (@(posedge clk) disable iff (!reset)
    !(i_gnt && d_gnt));

  aMemReqIsGrant: assert property (@(posedge clk) disable iff (!reset)
    mem_req == (i_gnt || d_gnt));

  aScntBounded: assert property (@(posedge clk) disable iff (!reset)
    w_scnt <= SW'(STARVE_MAX));

endmodule

// File: tb/tb_umem_arbiter.sv
// Testbench for umem_arbiter: directed scenarios with literal expectations,
// then randomized fetch/data traffic checked every cycle against a
// transaction-level model (next-free cycle, response queue, word memory).
module tb_umem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [3:0]  d_byteen;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  umem_arbiter #(
    .LAT        (LAT),
    .STARVE_MAX (SMAX),
    .AW         (32),
    .DW         (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_byteen   (d_byteen),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byteen (mem_byteen),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Values the stimulus wants on the inputs for the next cycle.
  logic        drvRst;
  logic        drvIReq;
  logic [31:0] drvIAddr;
  logic        drvDReq;
  logic        drvDWe;
  logic [31:0] drvDAddr;
  logic [3:0]  drvDBe;
  logic [31:0] drvDWdata;

  // Transaction-level reference model.
  typedef struct {
    longint      due;
    bit          isI;
    bit          isW;
    logic [31:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [31:0] memM [int unsigned];
  longint      cyc;
  longint      nextFree;
  int          scntM;
  logic        expGi;
  logic        expGd;

  int total;
  int bad;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    int unsigned k;
    k = int'(a[31:2]);
    return memM.exists(k) ? memM[k] : 32'h0;
  endfunction

  task automatic memWrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    int unsigned k;
    logic [31:0] w;
    k = int'(a[31:2]);
    w = memRead(a);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
    end
    memM[k] = w;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge,
  // then advance the model as the next rising edge will.
  task automatic applyStimulus();
    logic        respNow;
    logic        expIrv;
    logic        expDrv;
    logic [31:0] expIrd;
    logic [31:0] expDrd;
    @(posedge clk);
    #1;
    reset    = drvRst;
    i_req    = drvIReq;
    i_addr   = drvIAddr;
    d_req    = drvDReq;
    d_we     = drvDWe;
    d_addr   = drvDAddr;
    d_byteen = drvDBe;
    d_wdata  = drvDWdata;
    mem_rdata = $urandom();
    if (drvRst && rq.size() > 0 && rq[0].due == cyc && !rq[0].isW) mem_rdata = rq[0].data;
    @(negedge clk);
    expGi = 1'b0;
    expGd = 1'b0;
    if (!drvRst) begin
      checkOutput("rst_gnt", {62'd0, i_gnt, d_gnt}, 64'd0);
      checkOutput("rst_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
      checkOutput("rst_memctl", {58'd0, mem_req, mem_we, mem_byteen}, 64'd0);
      checkOutput("rst_memaddr", {mem_addr, mem_wdata}, 64'd0);
      checkOutput("rst_rdata", {i_rdata, d_rdata}, 64'd0);
      rq.delete();
      scntM    = 0;
      nextFree = 0;
    end else begin
      if (cyc >= nextFree) begin
        if (drvIReq && drvDReq) begin
          if (scntM == SMAX) expGi = 1'b1;
          else expGd = 1'b1;
        end else if (drvIReq) begin
          expGi = 1'b1;
        end else if (drvDReq) begin
          expGd = 1'b1;
        end
      end
      checkOutput("i_gnt", {63'd0, i_gnt}, {63'd0, expGi});
      checkOutput("d_gnt", {63'd0, d_gnt}, {63'd0, expGd});
      checkOutput("mem_req", {63'd0, mem_req}, {63'd0, expGi | expGd});
      if (expGi) begin
        checkOutput("fetch_addr", {32'd0, mem_addr}, {32'd0, drvIAddr});
        checkOutput("fetch_ctl", {59'd0, mem_we, mem_byteen}, 64'd0);
      end
      if (expGd) begin
        checkOutput("data_addr", {32'd0, mem_addr}, {32'd0, drvDAddr});
        checkOutput("data_we", {63'd0, mem_we}, {63'd0, drvDWe});
        checkOutput("data_be", {60'd0, mem_byteen}, {60'd0, drvDWe ? drvDBe : 4'd0});
        if (drvDWe) checkOutput("data_wdata", {32'd0, mem_wdata}, {32'd0, drvDWdata});
      end
      respNow = (rq.size() > 0) && (rq[0].due == cyc);
      expIrv  = respNow && rq[0].isI;
      expDrv  = respNow && !rq[0].isI;
      expIrd  = expIrv ? rq[0].data : 32'h0;
      expDrd  = (expDrv && !rq[0].isW) ? rq[0].data : 32'h0;
      checkOutput("i_rvalid", {63'd0, i_rvalid}, {63'd0, expIrv});
      checkOutput("d_rvalid", {63'd0, d_rvalid}, {63'd0, expDrv});
      checkOutput("i_rdata", {32'd0, i_rdata}, {32'd0, expIrd});
      checkOutput("d_rdata", {32'd0, d_rdata}, {32'd0, expDrd});
      if (respNow) void'(rq.pop_front());
      if (expGi) begin
        rq.push_back('{cyc + LAT, 1'b1, 1'b0, memRead(drvIAddr)});
        scntM    = 0;
        nextFree = cyc + LAT;
      end
      if (expGd) begin
        if (drvDWe) begin
          memWrite(drvDAddr, drvDBe, drvDWdata);
          rq.push_back('{cyc + LAT, 1'b0, 1'b1, 32'h0});
        end else begin
          rq.push_back('{cyc + LAT, 1'b0, 1'b0, memRead(drvDAddr)});
        end
        if (drvIReq && scntM < SMAX) scntM++;
        nextFree = cyc + LAT;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    drvIReq = 1'b0;
    drvDReq = 1'b0;
    for (int k = 0; k < n; k++) applyStimulus();
  endtask

  task automatic setData(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    drvDReq   = 1'b1;
    drvDWe    = we;
    drvDAddr  = a;
    drvDBe    = be;
    drvDWdata = wd;
  endtask

  initial begin
    logic iPend;
    logic dPend;
    total = 0;
    bad   = 0;
    cyc   = 0;
    nextFree = 0;
    scntM = 0;
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_byteen = '0; d_wdata = '0; mem_rdata = '0;
    drvRst = 1'b0; drvIReq = 1'b0; drvIAddr = '0; drvDReq = 1'b0;
    drvDWe = 1'b0; drvDAddr = '0; drvDBe = '0; drvDWdata = '0;

    // Reset held with a request present: nothing may be granted.
    drvIReq  = 1'b1;
    drvIAddr = 32'h3000;
    applyStimulus();
    checkOutput("pin_rst_i_gnt", {63'd0, i_gnt}, 64'd0);
    checkOutput("pin_rst_mem_req", {63'd0, mem_req}, 64'd0);
    applyStimulus();
    drvRst = 1'b1;

    // Lone fetch, held so a second fetch is accepted with the first response.
    memM[32'hC00] = 32'h24010001;
    applyStimulus();
    checkOutput("pin_t1_gnt", {63'd0, i_gnt}, 64'd1);
    checkOutput("pin_t1_addr", {32'd0, mem_addr}, 64'h3000);
    applyStimulus();
    checkOutput("pin_t1_busy", {63'd0, i_gnt}, 64'd0);
    applyStimulus();
    checkOutput("pin_t1_rvalid", {63'd0, i_rvalid}, 64'd1);
    checkOutput("pin_t1_rdata", {32'd0, i_rdata}, 64'h24010001);
    checkOutput("pin_t1_regnt", {63'd0, i_gnt}, 64'd1);
    idle(2);

    // Simultaneous fetch and data read: data goes first.
    memM[32'h4] = 32'h11112222;
    drvIReq = 1'b1;
    setData(1'b0, 32'h10, 4'hF, 32'h0);
    applyStimulus();
    checkOutput("pin_t2_dgnt", {62'd0, i_gnt, d_gnt}, 64'd1);
    drvDReq = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("pin_t2_igntc2", {63'd0, i_gnt}, 64'd1);
    checkOutput("pin_t2_drdata", {31'd0, d_rvalid, d_rdata}, 64'h1_1111_2222);
    drvIReq = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("pin_t2_irvalid", {31'd0, i_rvalid, i_rdata}, 64'h1_2401_0001);
    idle(1);

    // Both held: four data wins, then the fetch is forced through.
    drvIReq = 1'b1;
    setData(1'b0, 32'h20, 4'hF, 32'h0);
    for (int k = 0; k <= 10; k++) begin
      applyStimulus();
      if (k == 6) checkOutput("pin_t3_d4", {62'd0, i_gnt, d_gnt}, 64'd1);
      if (k == 8) begin
        checkOutput("pin_t3_istarve", {62'd0, i_gnt, d_gnt}, 64'd2);
        drvIReq = 1'b0;
      end
    end
    idle(2);

    // Partial write, then a write with no enables, then read back.
    setData(1'b1, 32'h4, 4'b0011, 32'hAABBCCDD);
    applyStimulus();
    checkOutput("pin_t4_wctl", {58'd0, d_gnt, mem_we, mem_byteen}, 64'h33);
    drvDReq = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("pin_t4_ack", {31'd0, d_rvalid, d_rdata}, 64'h1_0000_0000);
    setData(1'b1, 32'h4, 4'b0000, 32'hFFFFFFFF);
    applyStimulus();
    checkOutput("pin_t6_gnt", {63'd0, d_gnt}, 64'd1);
    drvDReq = 1'b0;
    applyStimulus();
    setData(1'b0, 32'h4, 4'hF, 32'h0);
    applyStimulus();
    checkOutput("pin_t6_ack", {62'd0, d_rvalid, d_gnt}, 64'd3);
    drvDReq = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("pin_t6_rdback", {32'd0, d_rdata}, 64'h0000_CCDD);

    // Reset in the middle of a read: response dropped, fresh fetch accepted.
    setData(1'b0, 32'h10, 4'hF, 32'h0);
    applyStimulus();
    checkOutput("pin_t5_gnt", {63'd0, d_gnt}, 64'd1);
    drvDReq = 1'b0;
    drvIReq = 1'b1;
    drvRst  = 1'b0;
    applyStimulus();
    drvRst = 1'b1;
    applyStimulus();
    checkOutput("pin_t5_norv", {62'd0, d_rvalid, i_rvalid}, 64'd0);
    checkOutput("pin_t5_fresh", {63'd0, i_gnt}, 64'd1);
    idle(3);

    // Random traffic: each side raises a request and holds it until accepted.
    iPend = 1'b0;
    dPend = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!iPend && $urandom_range(0, 3) != 0) begin
        iPend    = 1'b1;
        drvIAddr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dPend && $urandom_range(0, 2) != 0) begin
        dPend = 1'b1;
        setData(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                4'($urandom()), $urandom());
      end
      drvIReq = iPend;
      drvDReq = dPend;
      drvRst  = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      applyStimulus();
      if (expGi) iPend = 1'b0;
      if (expGd) dPend = 1'b0;
    end
    drvRst = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/umem_arbiter.md
Name: umem_arbiter

Overview:
- Shares one single-port unified memory between the F-stage instruction fetch port and the M-stage data port.
- Accepts at most one transaction at a time, which the memory completes after a fixed latency.
- Data requests normally win. A starvation counter guarantees instruction fetch forward progress.
- The pipeline's stall logic uses the grant/valid handshakes in place of the ideal zero-wait memory interface.

Parameters:
- LAT, 2, memory latency in cycles from accepted request to rdata valid/write done; legal range >=1.
- STARVE_MAX, 4, number of consecutive contested data wins before instruction fetch is forced to win once; >=1.
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with stable i_addr until i_gnt
- i_addr  in  AW  fetch byte address (word aligned)
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch data valid this cycle
- i_rdata  out  DW  fetch data
- d_req  in  1  data request; held with stable fields until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data byte address
- d_byteen  in  DW/8  write byte enables
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  read data valid / write acknowledge this cycle
- d_rdata  out  DW  read data
- mem_req  out  1  memory transaction start, one-cycle pulse
- mem_we  out  1  memory write
- mem_addr  out  AW  memory address
- mem_byteen  out  DW/8  memory byte enables
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  valid exactly LAT cycles after mem_req

Behaviour:
- State:
  - busy counter cnt (0..LAT)
  - owner register (NONE / I / D)
  - starvation counter scnt (0..STARVE_MAX)
- Reset (reset = 0, async):
  - cnt = 0, owner = NONE, scnt = 0.
  - All outputs are 0 while reset is held: gnt, rvalid, mem_req, and all data/address buses.
- free = (cnt == 0) || (cnt == 1).
- Arbitration is combinational and happens only when free:
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both requesting: grant D unless scnt == STARVE_MAX, in which case grant I.
- On a grant in cycle T:
  - The granted *_gnt = 1 and mem_req = 1 in cycle T.
  - mem_addr, mem_we, mem_wdata and mem_byteen come from the winner.
  - For a fetch or data read: mem_we = 0 and mem_byteen = 0.
  - For a data write: mem_byteen = d_byteen.
  - At the end of T: cnt <= LAT, owner <= winner.
- When not granting: cnt decrements if nonzero; owner <= NONE when cnt reaches 0.
- Response in cycle T+LAT (cnt == 1):
  - The owner's *_rvalid = 1 and *_rdata = mem_rdata.
  - A write response has rdata = 0.
  - The non-owner's rdata = 0.
- Back-to-back: a new grant may occur in the same cycle as the previous response. Throughput is one transaction per LAT cycles; with LAT = 1, one per cycle.
- Starvation counter:
  - scnt increments (saturating) when D is granted while i_req = 1.
  - scnt clears when I is granted.
  - Otherwise it holds.
- A write with d_byteen = 0 is still a full transaction: it is acknowledged and the memory performs no change.
- Requests that arrive while not free get no grant and must be held. Dropping a request before its grant is a protocol violation; the arbiter simply never grants it.
- Reset asserted mid-transaction: the in-flight response is discarded (no rvalid after reset release) and scnt clears.
- i_gnt and d_gnt are never both 1. mem_req == i_gnt | d_gnt.

Decomposition:
- Shared package umem_pkg:
  - owner encoding constants OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2
  - default LAT / STARVE_MAX
- Sub-module umem_prio_sel holds the winner selection and starvation counter:
  - inputs: i_req, d_req, free
  - outputs: sel_i, sel_d, plus the scnt register
- The top level holds cnt, owner, and the muxing.

Test Plan:
- LAT = 2; only i_req, i_addr = 0x3000. Expect i_gnt and mem_req in cycle 0. Memory drives 0x24010001 in cycle 2. Expect i_rvalid = 1 with i_rdata = 0x24010001 in cycle 2, plus a second grant in cycle 2 if i_req is still high.
- LAT = 2; i_req and d_req raised together in cycle 0 (d read 0x0010). Expect d_gnt in cycle 0, i_gnt in cycle 2, d_rvalid in cycle 2, i_rvalid in cycle 4.
- STARVE_MAX = 4, LAT = 1; i_req and d_req both held high continuously. Expect d_gnt in cycles 0–3, i_gnt in cycle 4, then D again in cycles 5–8, repeating in a 1-in-5 pattern.
- d write with d_addr = 0x0004, d_byteen = 4'b0011, d_wdata = 0xAABBCCDD. Expect mem_we = 1 and mem_byteen = 0011 on the grant cycle, then d_rvalid = 1 with d_rdata = 0 at T+LAT.
- Assert reset (drive low) in cycle 1 of a LAT = 3 read, release in cycle 2. Expect no rvalid in cycle 3, all outputs 0 during reset, and a fresh request granted immediately after release.
- LAT = 1, d_we = 1 with d_byteen = 0. Expect the grant and ack next cycle, and the memory contents unchanged on a subsequent read.
